// File: rtl/led_status_driver.sv
// Six-LED status driver with SOLID, BLINK, FLASH and OFF display modes.
// Define LED_PWM_EN to gate the LEDs with a free-running brightness PWM.
module led_status_driver #(
  parameter int CLOCK_FREQ  = 125_000_000,
  parameter int BLINK_HZ    = 2,
  parameter int FLASH_COUNT = 3,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          in_data,
  input  logic [1:0]          in_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [5:0]          leds
);

  localparam int HP_RAW  = CLOCK_FREQ / (2 * BLINK_HZ);
  localparam int HP      = (HP_RAW > 0) ? HP_RAW : 1;
  localparam int HP_W    = (HP > 1) ? $clog2(HP) : 1;
  localparam int FC_RAW  = $clog2(FLASH_COUNT + 1);
  localparam int FC_W    = (FC_RAW > 0) ? FC_RAW : 1;
  localparam int FC_LASTI = (FLASH_COUNT > 0) ? FLASH_COUNT - 1 : 0;

  localparam logic [HP_W-1:0] HP_LAST = HP_W'(HP - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FC_LASTI);

  // Encodings match in_mode so an accepted mode maps straight onto a state.
  typedef enum logic [1:0] {
    S_SOLID = 2'b00,
    S_BLINK = 2'b01,
    S_FLASH = 2'b10,
    S_OFF   = 2'b11
  } state_t;

  state_t          state, state_next;
  logic [5:0]      pattern, pattern_next;
  logic            phase, phase_next;
  logic [HP_W-1:0] hp_cnt, hp_next;
  logic [FC_W-1:0] flash_cnt, flash_next;
  logic [5:0]      leds_next;
  logic            gate;
  logic            accept;
  logic            hp_wrap;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Full-scale brightness must stay lit through the counter's top value.
  assign gate = (pwm_cnt < brightness) || (&brightness);
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign gate              = 1'b1;
`endif

  assign in_ready = (state != S_FLASH);
  assign accept   = in_valid && in_ready;
  assign hp_wrap  = (hp_cnt == HP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_OFF;
      pattern   <= '0;
      phase     <= 1'b0;
      hp_cnt    <= '0;
      flash_cnt <= '0;
      leds      <= '0;
    end else begin
      state     <= state_next;
      pattern   <= pattern_next;
      phase     <= phase_next;
      hp_cnt    <= hp_next;
      flash_cnt <= flash_next;
      leds      <= leds_next;
    end
  end

  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    phase_next   = phase;
    hp_next      = hp_cnt;
    flash_next   = flash_cnt;
    leds_next    = '0;

    case (state)
      S_SOLID: leds_next = pattern & {6{gate}};
      S_BLINK, S_FLASH: leds_next = phase ? (pattern & {6{gate}}) : 6'h00;
      default: leds_next = 6'h00;
    endcase

    if (state == S_BLINK || state == S_FLASH) begin
      if (hp_wrap) begin
        hp_next    = '0;
        phase_next = ~phase;
      end else begin
        hp_next = hp_cnt + HP_W'(1);
      end
    end

    // A flash pulse is complete at the end of its off-phase.
    if (state == S_FLASH && hp_wrap && !phase) begin
      if (flash_cnt == FC_LAST) begin
        state_next = S_SOLID;
        flash_next = '0;
        phase_next = 1'b0;
        hp_next    = '0;
      end else begin
        flash_next = flash_cnt + FC_W'(1);
      end
    end

    if (accept) begin
      state_next   = state_t'(in_mode);
      pattern_next = in_data;
      hp_next      = '0;
      flash_next   = '0;
      phase_next   = (in_mode == S_BLINK || in_mode == S_FLASH);
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed self-checking bench for led_status_driver at HP=4, FLASH_COUNT=3.
module tb_led_status_driver;

  logic       clk;
  logic       rst;
  logic [5:0] in_data;
  logic [1:0] in_mode;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] brightness;
  logic [5:0] leds;

  int total_checks;
  int passed_checks;

  localparam logic [1:0] M_SOLID = 2'b00;
  localparam logic [1:0] M_BLINK = 2'b01;
  localparam logic [1:0] M_FLASH = 2'b10;
  localparam logic [1:0] M_OFF   = 2'b11;

  led_status_driver #(
    .CLOCK_FREQ (8),
    .BLINK_HZ   (1),
    .FLASH_COUNT(3),
    .PWM_BITS   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .brightness(brightness),
    .leds      (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    total_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end else begin
      passed_checks++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] data, input logic [1:0] mode);
    in_data  = data;
    in_mode  = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Phase-accurate on/off expectation counted from the first cycle after accept.
  task automatic checkBlink(input string tag, input logic [5:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, 8'(leds), (i % 8 < 4) ? 8'(pat) : 8'h00);
    end
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 6'h00;
    in_mode    = M_OFF;
    brightness = 4'hF;

    tick();
    tick();
    checkOutput("reset_leds", 8'(leds), 8'h00);
    checkOutput("reset_ready", 8'(in_ready), 8'h01);
    rst = 1'b0;
    tick();
    checkOutput("off_leds", 8'(leds), 8'h00);

    applyStimulus(6'h2A, M_SOLID);
    tick();
    checkOutput("solid_leds", 8'(leds), 8'h2A);
    checkOutput("solid_ready", 8'(in_ready), 8'h01);
    tick();
    checkOutput("solid_hold", 8'(leds), 8'h2A);

`ifdef LED_PWM_EN
    applyStimulus(6'h3F, M_SOLID);
    brightness = 4'd4;
    tick();
    begin
      int lit;
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (leds == 6'h3F) lit++;
      end
      checkOutput("pwm_duty4", 8'(lit), 8'd4);
    end
    brightness = 4'd0;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput("pwm_zero", 8'(leds), 8'h00);
    end
    brightness = 4'hF;
    tick();
    tick();
    checkOutput("pwm_full", 8'(leds), 8'h3F);
`else
    brightness = 4'd0;
    tick();
    tick();
    checkOutput("no_pwm_gate", 8'(leds), 8'h2A);
    brightness = 4'hF;
`endif

    applyStimulus(6'h3F, M_BLINK);
    checkOutput("blink_ready", 8'(in_ready), 8'h01);
    checkBlink("blink", 6'h3F, 14);
    applyStimulus(6'h3F, M_BLINK);
    checkBlink("blink_restart", 6'h3F, 8);

    applyStimulus(6'h3F, M_OFF);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("off_from_blink", 8'(leds), 8'h00);
    end

    applyStimulus(6'h15, M_FLASH);
    checkOutput("flash_busy", 8'(in_ready), 8'h00);
    in_data  = 6'h01;
    in_mode  = M_SOLID;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checkOutput("flash_leds", 8'(leds), (i % 8 < 4) ? 8'h15 : 8'h00);
      checkOutput("flash_ready", 8'(in_ready), (i < 23) ? 8'h00 : 8'h01);
      if (i == 20) in_valid = 1'b0;
    end
    tick();
    checkOutput("flash_to_solid", 8'(leds), 8'h15);
    checkOutput("flash_done_ready", 8'(in_ready), 8'h01);
    tick();
    checkOutput("flash_solid_hold", 8'(leds), 8'h15);

    applyStimulus(6'h15, M_FLASH);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("pre_abort_leds", 8'(leds), 8'h15);
    rst = 1'b1;
    #1;
    checkOutput("abort_leds", 8'(leds), 8'h00);
    checkOutput("abort_ready", 8'(in_ready), 8'h01);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("post_abort_leds", 8'(leds), 8'h00);
      checkOutput("post_abort_ready", 8'(in_ready), 8'h01);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
